// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding, error
// codes and the instruction-word address helper.
package loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_LENGTH   = 2'b01;
  localparam logic [1:0] ERR_CHECKSUM = 2'b10;

  // Byte address of instruction word 'index' (32-bit wrap-around).
  function automatic logic [31:0] word_address(input logic [31:0] base,
                                               input logic [15:0] index);
    return base + {14'd0, index, 2'b00};
  endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// Collects four big-endian bytes into a 32-bit word. The finished word and
// a one-cycle word_valid appear in the cycle after the fourth byte.
module loader_word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_valid,
  output logic        o_last_byte
);

  logic [23:0] r_shift;
  logic [1:0]  r_count;
  logic [31:0] r_word;
  logic        r_word_valid;

  // Shift bytes in MSB first; emit the word on the fourth byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift      <= '0;
      r_count      <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_clear) begin
        r_shift <= '0;
        r_count <= '0;
      end else if (i_accept) begin
        if (r_count == 2'd3) begin
          r_word       <= {r_shift, i_byte};
          r_word_valid <= 1'b1;
          r_count      <= '0;
        end else begin
          r_shift <= {r_shift[15:0], i_byte};
          r_count <= r_count + 2'd1;
        end
      end
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_word_valid;
  assign o_last_byte  = (r_count == 2'd3);

endmodule

// File: rtl/program_loader.sv
// Streams a length-prefixed program into instruction memory while holding
// the CPU in reset. Optional trailing checksum byte: LOADER_CHECKSUM_EN.
// Handshake: a byte transfers on a rising edge where ByteValid and
// ByteReady are both 1; ByteValid may drop at any time without data loss.
module program_loader
  import loader_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 54,
  parameter logic [31:0] BASE_ADDRESS = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic        MemWrite,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        CpuReset,
  output logic        Busy,
  output logic        Done,
  output logic [1:0]  ErrorCode,
  output state_t      o_dbg_state
);

  localparam logic [31:0] LP_DEPTH = MEMORY_DEPTH[31:0];

  state_t      r_state;
  logic        r_byte_ready;
  logic        r_busy;
  logic        r_done;
  logic        r_cpu_reset;
  logic [1:0]  r_error;
  logic [15:0] r_len;
  logic [15:0] r_index;
  logic [31:0] r_mem_addr;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  r_csum;
`endif

  logic        w_accept;
  logic        w_start;
  logic [15:0] w_len;
  logic        w_len_bad;
  logic        w_last_byte;
  logic        w_word_last;
  logic [31:0] w_word;
  logic        w_word_valid;

  assign w_accept    = ByteValid & r_byte_ready;
  assign w_start     = start & ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                (r_state == ST_ERROR));
  assign w_len       = {r_len[15:8], ByteIn};
  assign w_len_bad   = (w_len == 16'd0) || ({16'd0, w_len} > LP_DEPTH);
  assign w_word_last = w_accept & w_last_byte & (r_state == ST_DATA);

  loader_word_assembler u_asm (
    .clk          (clk),
    .rst_n        (reset),
    .i_clear      (w_start),
    .i_accept     (w_accept & (r_state == ST_DATA)),
    .i_byte       (ByteIn),
    .o_word       (w_word),
    .o_word_valid (w_word_valid),
    .o_last_byte  (w_last_byte)
  );

  // Loader FSM with all status outputs registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_byte_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_cpu_reset  <= 1'b0;
      r_error      <= ERR_NONE;
      r_len        <= '0;
      r_index      <= '0;
      r_mem_addr   <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            r_state      <= ST_LEN_HI;
            r_byte_ready <= 1'b1;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_cpu_reset  <= 1'b0;
            r_error      <= ERR_NONE;
            r_index      <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
          end
        end
        ST_LEN_HI: begin
          if (w_accept) begin
            r_len   <= {ByteIn, 8'h00};
            r_state <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (w_accept) begin
            r_len <= w_len;
            if (w_len_bad) begin
              r_state      <= ST_ERROR;
              r_error      <= ERR_LENGTH;
              r_byte_ready <= 1'b0;
              r_busy       <= 1'b0;
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_accept) begin
`ifdef LOADER_CHECKSUM_EN
            r_csum <= r_csum + ByteIn;
`endif
            if (w_word_last) begin
              r_mem_addr <= word_address(BASE_ADDRESS, r_index);
              r_index    <= r_index + 16'd1;
              if (r_index == r_len - 16'd1) begin
`ifdef LOADER_CHECKSUM_EN
                r_state      <= ST_CHECK;
`else
                r_state      <= ST_DONE;
                r_done       <= 1'b1;
                r_cpu_reset  <= 1'b1;
                r_busy       <= 1'b0;
                r_byte_ready <= 1'b0;
`endif
              end
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (w_accept) begin
            r_byte_ready <= 1'b0;
            r_busy       <= 1'b0;
            if (ByteIn == r_csum) begin
              r_state     <= ST_DONE;
              r_done      <= 1'b1;
              r_cpu_reset <= 1'b1;
            end else begin
              r_state <= ST_ERROR;
              r_error <= ERR_CHECKSUM;
            end
          end
        end
`endif
        default: begin
          r_state      <= ST_IDLE;
          r_byte_ready <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign ByteReady    = r_byte_ready;
  assign MemWrite     = w_word_valid;
  assign MemAddress   = r_mem_addr;
  assign MemWriteData = w_word;
  assign CpuReset     = r_cpu_reset;
  assign Busy         = r_busy;
  assign Done         = r_done;
  assign ErrorCode    = r_error;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader; works with or without
// LOADER_CHECKSUM_EN.
module tb_program_loader;
  import loader_pkg::*;

  localparam int          DEPTH = 54;
  localparam logic [31:0] BASE  = 32'h0040_0000;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  // Clock / reset
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        MemWrite;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        CpuReset;
  logic        Busy;
  logic        Done;
  logic [1:0]  ErrorCode;
  state_t      dbg_state;

  always #5 clk = ~clk;

  program_loader #(.MEMORY_DEPTH(DEPTH), .BASE_ADDRESS(BASE)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ByteIn       (ByteIn),
    .ByteValid    (ByteValid),
    .ByteReady    (ByteReady),
    .MemWrite     (MemWrite),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .CpuReset     (CpuReset),
    .Busy         (Busy),
    .Done         (Done),
    .ErrorCode    (ErrorCode),
    .o_dbg_state  (dbg_state)
  );

  // Scoreboard
  int          errors = 0;
  int          checks = 0;
  logic [31:0] prog [0:63];
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] got_addr_q[$];
  logic [31:0] got_data_q[$];

  // Capture every memory write strobe, one entry per high cycle.
  always @(negedge clk) begin
    if (reset === 1'b1 && MemWrite === 1'b1) begin
      got_addr_q.push_back(MemAddress);
      got_data_q.push_back(MemWriteData);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference model: modulo-256 sum of all data bytes of the first n words.
  function automatic logic [7:0] model_sum(input int n);
    int s;
    s = 0;
    for (int i = 0; i < n; i++) begin
      s += prog[i][31:24] + prog[i][23:16] + prog[i][15:8] + prog[i][7:0];
    end
    return s[7:0];
  endfunction

  // Driver tasks; all driving happens at the falling edge.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse_start);
    int t;
    ByteValid = 1'b0;
    repeat (gap) @(negedge clk);
    ByteIn    = b;
    ByteValid = 1'b1;
    if (pulse_start) start = 1'b1;
    t = 0;
    while (ByteReady !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("byte_ready_before_accept", {31'd0, ByteReady}, 32'd1);
    @(negedge clk);
    ByteValid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy",      {31'd0, Busy},      32'd1);
    check("start_ready",     {31'd0, ByteReady}, 32'd1);
    check("start_cpureset",  {31'd0, CpuReset},  32'd0);
    check("start_done",      {31'd0, Done},      32'd0);
    check("start_errorcode", {30'd0, ErrorCode}, {30'd0, ERR_NONE});
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check({tag, "_write_count"}, 32'(got_addr_q.size()), 32'(exp_addr_q.size()));
    n = (got_addr_q.size() < exp_addr_q.size()) ? got_addr_q.size() : exp_addr_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_addr"}, got_addr_q[i], exp_addr_q[i]);
      check({tag, "_data"}, got_data_q[i], exp_data_q[i]);
    end
    got_addr_q.delete(); got_data_q.delete();
    exp_addr_q.delete(); exp_data_q.delete();
  endtask

  // One complete load: start, stream, then check writes and final status.
  task automatic run_load(input string tag, input int n_len, input int gap_mode,
                          input int start_at, input int csum_delta);
    logic [7:0]  bq[$];
    logic [15:0] len16;
    logic [1:0]  exp_err;
    bit          valid;
    int          gap;
    valid = (n_len >= 1) && (n_len <= DEPTH);
    len16 = n_len[15:0];
    got_addr_q.delete(); got_data_q.delete();
    exp_addr_q.delete(); exp_data_q.delete();
    bq.push_back(len16[15:8]);
    bq.push_back(len16[7:0]);
    if (valid) begin
      for (int i = 0; i < n_len; i++) begin
        bq.push_back(prog[i][31:24]); bq.push_back(prog[i][23:16]);
        bq.push_back(prog[i][15:8]);  bq.push_back(prog[i][7:0]);
        exp_addr_q.push_back(BASE + 32'(4 * i));
        exp_data_q.push_back(prog[i]);
      end
      if (CSUM_ON) bq.push_back(model_sum(n_len) + 8'(csum_delta));
    end
    if (!valid)                          exp_err = 2'b01;
    else if (CSUM_ON && csum_delta != 0) exp_err = 2'b10;
    else                                 exp_err = 2'b00;

    pulse_start();
    for (int i = 0; i < bq.size(); i++) begin
      gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
      send_byte(bq[i], gap, i == start_at);
    end
    // One falling edge after the last accepting edge.
    check({tag, "_done_next"},  {31'd0, Done},      {31'd0, exp_err == 2'b00});
    check({tag, "_errorcode"},  {30'd0, ErrorCode}, {30'd0, exp_err});
    check({tag, "_busy_end"},   {31'd0, Busy},      32'd0);
    check({tag, "_ready_end"},  {31'd0, ByteReady}, 32'd0);
    // Offer extra bytes that must be ignored.
    ByteIn    = 8'hA5;
    ByteValid = 1'b1;
    repeat (3) @(negedge clk);
    ByteValid = 1'b0;
    check({tag, "_ready_hold"}, {31'd0, ByteReady}, 32'd0);
    check({tag, "_cpureset"},   {31'd0, CpuReset},  {31'd0, exp_err == 2'b00});
    check({tag, "_done_hold"},  {31'd0, Done},      {31'd0, exp_err == 2'b00});
    compare_writes(tag);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"},    {31'd0, ByteReady}, 32'd0);
    check({tag, "_memwrite"}, {31'd0, MemWrite},  32'd0);
    check({tag, "_addr"},     MemAddress,         32'd0);
    check({tag, "_wdata"},    MemWriteData,       32'd0);
    check({tag, "_cpureset"}, {31'd0, CpuReset},  32'd0);
    check({tag, "_busy"},     {31'd0, Busy},      32'd0);
    check({tag, "_done"},     {31'd0, Done},      32'd0);
    check({tag, "_err"},      {30'd0, ErrorCode}, 32'd0);
  endtask

  task automatic load_example();
    prog[0] = 32'h2008_0005;
    prog[1] = 32'h0000_0008;
  endtask

  // Global time limit so the run always ends.
  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  // Directed and randomized sequence
  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    ByteIn    = 8'h00;
    ByteValid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;
    @(negedge clk);

    // Worked example, back-to-back bytes.
    load_example();
    check("example_checksum_model", {24'd0, model_sum(2)}, 32'h35);
    run_load("example", 2, 0, -1, 0);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum: writes stay, error reported.
    load_example();
    run_load("bad_csum", 2, 0, -1, 1);
`endif

    // Length out of range and zero length.
    run_load("len55", 55, 0, -1, 0);
    run_load("len0", 0, 0, -1, 0);
    run_load("len_big", 16'hFFFF, 0, -1, 0);

    // Reset in the middle of a load.
    load_example();
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h20, 0, 1'b0);
    send_byte(8'h08, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h05, 0, 1'b0);
    send_byte(8'h00, 0, 1'b0);
    check("midload_addr_before_reset", MemAddress, BASE);
    reset = 1'b0;
    #1;
    check_reset_values("midload_reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_load("reload", 2, 0, -1, 0);

    // ByteValid toggling every cycle with start pulsed during DATA.
    load_example();
    run_load("toggle_start", 2, 1, 5, 0);

    // Boundary lengths.
    for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
    run_load("len_max", DEPTH, 2, -1, 0);
    prog[0] = $urandom;
    run_load("len1", 1, 1, -1, 0);

    // Randomized loads.
    for (int k = 0; k < 4; k++) begin
      int n;
      n = int'($urandom_range(1, DEPTH));
      for (int i = 0; i < n; i++) prog[i] = $urandom;
      run_load("random", n, int'($urandom_range(0, 2)), int'($urandom_range(2, 4 * n)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MEMORY_DEPTH, default 54: capacity of instruction memory in 32-bit words.
REQ-002 Parameter BASE_ADDRESS, default 32'h0040_0000: byte address of instruction word 0.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port reset  input  1: one clock; reset is asynchronous and active-low.
REQ-005 Port start  input  1: load request, sampled in IDLE, DONE and ERROR only.
REQ-006 Port ByteIn  input  8: incoming stream byte.
REQ-007 Port ByteValid  input  1: ByteIn valid.
REQ-008 Port ByteReady  output  1: loader accepts a byte this cycle.
REQ-009 Port MemWrite  output  1: one-cycle instruction-memory write strobe.
REQ-010 Port MemAddress  output  32: word-aligned byte address of the write.
REQ-011 Port MemWriteData  output  32: instruction word to write.
REQ-012 Port CpuReset  output  1: active-low processor reset; 0 holds the processor in reset.
REQ-013 Port Busy  output  1: load in progress.
REQ-014 Port Done  output  1: last load completed successfully.
REQ-015 Port ErrorCode  output  2: 00 none, 01 bad length, 10 checksum mismatch.

Function
REQ-016 Byte accepted only on a clk edge with ByteValid=1 and ByteReady=1; ByteValid gaps stall the FSM without data loss.
REQ-017 Stream format: length N (16-bit, big-endian, two bytes), then N words, each 4 bytes big-endian (first byte -> bits 31:24), then an optional checksum byte (REQ-029).
REQ-018 States: IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR.
REQ-019 IDLE/DONE/ERROR + start=1 -> LEN_HI; clears Done, ErrorCode, word index, checksum; CpuReset driven 0.
REQ-020 LEN_HI accept -> LEN_LO; LEN_LO accept -> ERROR with ErrorCode=01 when N=0 or N>MEMORY_DEPTH, else DATA.
REQ-021 ByteReady=1 exactly in LEN_HI, LEN_LO, DATA, CHECK; no stall on word completion.
REQ-022 DATA: on acceptance of the 4th byte of word i, MemWrite=1 for exactly the next cycle with MemWriteData=assembled word, MemAddress=BASE_ADDRESS+4*i (32-bit modulo).
REQ-023 Last byte of word N-1 moves DATA -> CHECK (macro defined) or DONE (undefined); the final MemWrite pulse still occurs in the following cycle.
REQ-024 DONE: Done=1, CpuReset=1, Busy=0; held until start or reset.
REQ-025 ERROR: CpuReset=0, Busy=0, Done=0, ErrorCode held; exit only via start or reset.
REQ-026 Busy=1 in LEN_HI, LEN_LO, DATA, CHECK; start is ignored while Busy=1.
REQ-027 Words already written before an error are not undone.

Reset
REQ-028 reset=0 forces IDLE immediately, including mid-load: ByteReady=0, MemWrite=0, MemAddress=0, MemWriteData=0, CpuReset=0, Busy=0, Done=0, ErrorCode=00, index/byte counters and checksum=0.

Configuration
REQ-029 LOADER_CHECKSUM_EN defined: CHECK state accepts one byte; it must equal the modulo-256 sum of all data bytes (length bytes excluded), else ERROR with ErrorCode=10; match -> DONE.
REQ-030 LOADER_CHECKSUM_EN undefined: no CHECK state, no checksum logic, ErrorCode 10 never produced.

Structure
REQ-031 Package loader_pkg holds the state enumeration and ErrorCode constants (ERR_NONE, ERR_LENGTH, ERR_CHECKSUM).
REQ-032 One sub-module, loader_word_assembler: shifts in bytes, counts 0..3, emits word plus one-cycle word_valid; FSM, address and checksum stay in program_loader.

Verification
REQ-033 Macro on; start, stream 00 02 20 08 00 05 00 00 00 08 35 -> writes 0x20080005@0x00400000, 0x00000008@0x00400004; Done=1, CpuReset=1, ErrorCode=00.
REQ-034 Stream 00 37 (N=55) -> ErrorCode=01, no MemWrite, CpuReset=0, ByteReady=0.
REQ-035 Stream of REQ-033 with checksum 36 -> both writes occur, ErrorCode=10, Done=0, CpuReset=0.
REQ-036 reset=0 after 5 data bytes, then restart with the REQ-033 stream -> reset values immediately; reload starts again at 0x00400000 with identical writes.
REQ-037 REQ-033 stream with ByteValid toggling each cycle, plus start pulsed during DATA -> identical writes and final state; start has no effect.
REQ-038 Macro off; REQ-033 stream without 35 -> Done=1 in the cycle after the last byte is accepted; ByteReady=0 afterwards.
